// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand/request and result bundle for the nibble-serial adder.
interface nibble_serial_adder_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit add/subtract computed one nibble per cycle through a single 4-bit lookahead adder.
module cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c
);
  logic [3:0] w_g, w_p;
  logic [3:1] w_c;
  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (&w_p[1:0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (&w_p[2:1] & w_g[0]) | (&w_p[2:0] & i_c);
  assign o_c    = w_g[3] | (w_p[3] & w_g[2]) | (&w_p[3:2] & w_g[1]) | (&w_p[3:1] & w_g[0]) | (&w_p & i_c);
  assign o_s    = w_p ^ {w_c, i_c};
endmodule

module nibble_serial_adder #(parameter int NIBBLES = 4) (
  input  logic clk,
  input  logic rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]    r_state;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_a, r_b, r_acc, r_sum;
  logic          r_cout, r_ovf;
  logic [3:0]    w_s;
  logic          w_co;
  logic          w_last;
  logic [W-1:0]  w_res;
  cla4 u_cla (
    .i_a(r_a[{r_idx, 2'b00} +: 4]),
    .i_b(r_b[{r_idx, 2'b00} +: 4]),
    .i_c(r_carry),
    .o_s(w_s),
    .o_c(w_co)
  );
  assign w_last = r_idx == IW'(NIBBLES - 1);
  // accumulator with the current slice merged in; on the last slice this is the full result
  always_comb begin
    w_res = r_acc;
    w_res[{r_idx, 2'b00} +: 4] = w_s;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == IDLE) begin
      if (bus.start) begin
        r_a     <= bus.a;
        r_b     <= bus.sub ? ~bus.b : bus.b;
        r_carry <= bus.sub ? 1'b1 : bus.cin;
        r_idx   <= '0;
        r_state <= RUN;
      end
    end else if (r_state == RUN) begin
      r_acc   <= w_res;
      r_carry <= w_co;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_sum   <= w_res;
        r_cout  <= w_co;
        r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_res[W-1] != r_a[W-1]);
        r_state <= DONE;
      end
    end else begin
      r_state <= IDLE;
    end
  end
  assign bus.busy = r_state == RUN;
  assign bus.done = r_state == DONE;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed checks of the nibble-serial adder with NIBBLES=4.
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0, passed = 0, failed = 0;
  nibble_serial_adder_if #(.NIBBLES(4)) bus ();
  nibble_serial_adder #(.NIBBLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; checks latency, result and a single-cycle done
  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic ci,
                    input logic s, input logic [15:0] es, input logic ec, input logic eo);
    int n;
    bus.a = a; bus.b = b; bus.cin = ci; bus.sub = s; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.a = ~a; bus.b = 16'h0F0F; bus.cin = ~ci; bus.sub = ~s;
    n = 1;
    chk({tag, ".busy"}, bus.busy, 1);
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, n, 5);
    chk({tag, ".sum"}, bus.sum, es);
    chk({tag, ".cout"}, bus.cout, ec);
    chk({tag, ".ovf"}, bus.ovf, eo);
    chk({tag, ".busy_in_done"}, bus.busy, 0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, bus.done, 0);
    chk({tag, ".sum_hold"}, bus.sum, es);
  endtask

  initial begin
    int nd, first;
    int td[4];
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.sum", bus.sum, 0);
    chk("rst.cout", bus.cout, 0);
    chk("rst.ovf", bus.ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op("add_basic", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op("sub", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op("add_cin", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
    // start re-pulsed during RUN with different operands must be ignored
    bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    nd = 0; first = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 2) begin bus.start = 1'b1; bus.a = 16'h0F0F; bus.b = 16'h0F0F; end
      if (i == 3) bus.start = 1'b0;
      if (bus.done) begin
        nd++;
        if (first == 0) first = i;
      end
    end
    chk("poke.done_count", nd, 1);
    chk("poke.lat", first, 5);
    chk("poke.sum", bus.sum, 16'h2345);
    // start held high: one acceptance every six cycles
    bus.a = 16'h0001; bus.b = 16'h0002; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    nd = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (bus.done && nd < 4) begin
        td[nd] = i;
        nd++;
        if (nd == 3) bus.start = 1'b0;
      end
    end
    chk("cont.done_count", nd, 3);
    chk("cont.first", td[0], 5);
    chk("cont.period1", td[1] - td[0], 6);
    chk("cont.period2", td[2] - td[1], 6);
    chk("cont.sum", bus.sum, 16'h0003);
    op("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    // reset in the third RUN cycle aborts with no done
    bus.a = 16'hFFFF; bus.b = 16'h0001; bus.cin = 1'b1; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort.busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", bus.busy, 0);
    chk("abort.done", bus.done, 0);
    chk("abort.sum", bus.sum, 0);
    chk("abort.cout", bus.cout, 0);
    chk("abort.ovf", bus.ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("abort.no_done", nd, 0);
    op("after_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 a  input  W  operand A; sampled at the accepting edge.
REQ-006 b  input  W  operand B; sampled at the accepting edge.
REQ-007 cin  input  1  carry-in for add; sampled at the accepting edge.
REQ-008 sub  input  1  0 = A+B+cin, 1 = A-B; sampled at the accepting edge.
REQ-009 busy  output  1  high while slices are being processed (RUN).
REQ-010 done  output  1  one-cycle result-valid pulse (DONE).
REQ-011 sum  output  W  registered result.
REQ-012 cout  output  1  registered final carry-out; for subtract, 1 = no borrow.
REQ-013 ovf  output  1  registered two's-complement signed overflow.

Function
REQ-014 The block SHALL instantiate the team's existing 4-bit lookahead adder once and reuse it for one nibble per RUN cycle.
REQ-015 FSM states SHALL be IDLE, RUN and DONE, with IDLE as the reset state.
REQ-016 IDLE with start=1 at an edge SHALL perform all of the following:
- latch a into A_reg;
- latch B_reg = sub ? ~b : b;
- set carry = sub ? 1 : cin (cin is ignored when sub=1);
- clear the nibble index to 0;
- go to RUN.
REQ-017 Each RUN edge SHALL perform all of the following:
- feed nibble[idx] of A_reg, nibble[idx] of B_reg and carry to the adder;
- write the adder sum into accumulator nibble[idx];
- load carry from the adder carry-out;
- increment idx.
REQ-018 At the RUN edge with idx = NIBBLES-1, the block SHALL:
- load sum from the completed accumulator;
- load cout from the final carry;
- load ovf = (A_reg[W-1] == B_reg[W-1]) && (result[W-1] != A_reg[W-1]);
- go to DONE.
REQ-019 DONE SHALL last exactly one cycle (done=1), then return to IDLE unconditionally.
REQ-020 Latency: start accepted at edge k -> done high between edges k+NIBBLES and k+NIBBLES+1.
REQ-021 The block SHALL ignore start in RUN and DONE; operands in flight SHALL NOT change.
REQ-022 With start held high continuously, a new operation SHALL be accepted every NIBBLES+2 cycles.
REQ-023 sum, cout and ovf SHALL change only at the edge entering DONE, and hold until the next such edge.
REQ-024 Arithmetic SHALL be modulo 2^W; carry beyond bit W-1 SHALL appear only on cout.
REQ-025 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; they SHALL never be high together.

Reset
REQ-026 rst_n=0 SHALL immediately force:
- state to IDLE;
- busy=0, done=0, sum=0, cout=0, ovf=0;
- idx, carry, A_reg, B_reg and accumulator to 0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-028 After rst_n rises, the first start seen at an edge SHALL be accepted normally.

Verification (NIBBLES=4)
REQ-029 a=0x1234, b=0x1111, cin=0, sub=0 -> done 5 cycles after the start edge; sum=0x2345, cout=0, ovf=0.
REQ-030 a=0xFFFF, b=0x0001, cin=0 (carry ripples through every nibble) -> sum=0x0000, cout=1, ovf=0.
REQ-031 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-032 a=0x0005, b=0x0007, sub=1, cin=1 (cin ignored) -> sum=0xFFFE, cout=0, ovf=0.
REQ-033 start pulsed again in RUN with a=0x0F0F -> ignored:
- result equals the first operation;
- exactly one done pulse;
- start held high continuously gives done every 6 cycles.
REQ-034 rst_n dropped in the 3rd RUN cycle -> busy, done, sum, cout and ovf read 0 at once; no done pulse follows.
